// File: rtl/pr_pkg.sv
// Shared defaults and FSM state encoding for the IF/ID pipeline register.
package pr_pkg;

  localparam int unsigned PR_XLEN      = 32;
  localparam logic [31:0] PR_NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } pr_state_e;

endpackage

// File: rtl/pr_bundle_reg.sv
// One held fetch bundle: PC, ISSUE_W instruction slots and their valids.
// Slots that arrive invalid are stored as NOP_INSTR.
module pr_bundle_reg
  import pr_pkg::*;
#(
  parameter int unsigned      ISSUE_W   = 2,
  parameter int unsigned      XLEN      = PR_XLEN,
  parameter logic [XLEN-1:0]  NOP_INSTR = XLEN'(PR_NOP_INSTR)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      load,
  input  logic                      clr,
  input  logic [XLEN-1:0]           pc_d,
  input  logic [ISSUE_W*XLEN-1:0]   instr_d,
  input  logic [ISSUE_W-1:0]        slot_valid_d,
  output logic [XLEN-1:0]           pc_q,
  output logic [ISSUE_W*XLEN-1:0]   instr_q,
  output logic [ISSUE_W-1:0]        slot_valid_q
);

  logic [ISSUE_W*XLEN-1:0] instr_sub_c;

  // NOP substitution is idempotent, so reloading from another bundle_reg is safe.
  always_comb begin
    instr_sub_c = instr_d;
    for (int unsigned k = 0; k < ISSUE_W; k++) begin
      if (!slot_valid_d[k]) begin
        instr_sub_c[k*XLEN +: XLEN] = NOP_INSTR;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q         <= '0;
      instr_q      <= '0;
      slot_valid_q <= '0;
    end else begin
      if (load) begin
        pc_q    <= pc_d;
        instr_q <= instr_sub_c;
      end
      if (clr) begin
        slot_valid_q <= '0;
      end else if (load) begin
        slot_valid_q <= slot_valid_d;
      end
    end
  end

endmodule

// File: rtl/pr_id_multi.sv
// Multi-issue IF/ID pipeline register with one skid entry, flush and a
// saturating count of cycles in which decode is presented no bundle.
module pr_id_multi
  import pr_pkg::*;
#(
  parameter int unsigned      ISSUE_W   = 2,
  parameter int unsigned      XLEN      = PR_XLEN,
  parameter logic [XLEN-1:0]  NOP_INSTR = XLEN'(PR_NOP_INSTR),
  parameter int unsigned      CNT_W     = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [XLEN-1:0]           pc_in,
  input  logic [ISSUE_W*XLEN-1:0]   instr_in,
  input  logic [ISSUE_W-1:0]        slot_valid_in,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [XLEN-1:0]           pc_out,
  output logic [ISSUE_W*XLEN-1:0]   instr_out,
  output logic [ISSUE_W-1:0]        slot_valid_out,
  input  logic                      bubble_clr,
  output logic [CNT_W-1:0]          bubble_cnt
);

  pr_state_e               state_q, state_d;
  logic                    in_ready_q, out_valid_q;
  logic [CNT_W-1:0]        bubble_q;

  logic                    in_fire_c, out_fire_c, in_take_c;
  logic                    main_load_c, main_from_skid_c, skid_load_c, clr_c;

  logic [XLEN-1:0]         skid_pc;
  logic [ISSUE_W*XLEN-1:0] skid_instr;
  logic [ISSUE_W-1:0]      skid_slot_valid;

  logic [XLEN-1:0]         main_pc_d;
  logic [ISSUE_W*XLEN-1:0] main_instr_d;
  logic [ISSUE_W-1:0]      main_slot_valid_d;

  assign in_fire_c  = in_valid & in_ready_q;
  assign out_fire_c = out_valid_q & out_ready;
  // A bundle with no valid slot is handshaken but never stored.
  assign in_take_c  = in_fire_c & (|slot_valid_in);

  // Next-state and datapath control
  always_comb begin
    state_d          = state_q;
    main_load_c      = 1'b0;
    main_from_skid_c = 1'b0;
    skid_load_c      = 1'b0;
    clr_c            = 1'b0;
    if (flush) begin
      state_d = EMPTY;
      clr_c   = 1'b1;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_take_c) begin
            main_load_c = 1'b1;
            state_d     = FULL;
          end
        end
        FULL: begin
          if (in_take_c && out_fire_c) begin
            main_load_c = 1'b1;
          end else if (in_take_c) begin
            skid_load_c = 1'b1;
            state_d     = SKID;
          end else if (out_fire_c) begin
            state_d = EMPTY;
          end
        end
        SKID: begin
          if (out_fire_c) begin
            main_load_c      = 1'b1;
            main_from_skid_c = 1'b1;
            state_d          = FULL;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d != SKID);
      out_valid_q <= (state_d != EMPTY);
    end
  end

  // Saturating bubble counter; clear wins over increment
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bubble_q <= '0;
    end else if (bubble_clr) begin
      bubble_q <= '0;
    end else if (!out_valid_q && (bubble_q != {CNT_W{1'b1}})) begin
      bubble_q <= bubble_q + CNT_W'(1);
    end
  end

  assign main_pc_d         = main_from_skid_c ? skid_pc         : pc_in;
  assign main_instr_d      = main_from_skid_c ? skid_instr      : instr_in;
  assign main_slot_valid_d = main_from_skid_c ? skid_slot_valid : slot_valid_in;

  pr_bundle_reg #(
    .ISSUE_W   (ISSUE_W),
    .XLEN      (XLEN),
    .NOP_INSTR (NOP_INSTR)
  ) u_main (
    .clk          (clk),
    .reset        (reset),
    .load         (main_load_c),
    .clr          (clr_c),
    .pc_d         (main_pc_d),
    .instr_d      (main_instr_d),
    .slot_valid_d (main_slot_valid_d),
    .pc_q         (pc_out),
    .instr_q      (instr_out),
    .slot_valid_q (slot_valid_out)
  );

  pr_bundle_reg #(
    .ISSUE_W   (ISSUE_W),
    .XLEN      (XLEN),
    .NOP_INSTR (NOP_INSTR)
  ) u_skid (
    .clk          (clk),
    .reset        (reset),
    .load         (skid_load_c),
    .clr          (clr_c),
    .pc_d         (pc_in),
    .instr_d      (instr_in),
    .slot_valid_d (slot_valid_in),
    .pc_q         (skid_pc),
    .instr_q      (skid_instr),
    .slot_valid_q (skid_slot_valid)
  );

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign bubble_cnt = bubble_q;

endmodule

// File: tb/tb_pr_id_multi.sv
// Bench for pr_id_multi: directed vector table plus random traffic on three
// configurations (2-wide, 1-wide, 4-wide with a 4-bit bubble counter).
module tb_pr_id_multi;

  localparam int ND = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset, in_valid, flush, out_ready, bubble_clr;
  logic [31:0]  pc_in;
  logic [127:0] instr_in;
  logic [3:0]   sv_in;

  logic         rdy0, rdy1, rdy2, vld0, vld1, vld2;
  logic [31:0]  pc0, pc1, pc2;
  logic [63:0]  ins0;
  logic [31:0]  ins1;
  logic [127:0] ins2;
  logic [1:0]   sv0;
  logic [0:0]   sv1;
  logic [3:0]   sv2;
  logic [15:0]  bub0, bub1;
  logic [3:0]   bub2;

  pr_id_multi #(.ISSUE_W(2), .XLEN(32), .NOP_INSTR(32'h0000_0000), .CNT_W(16)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy0), .pc_in(pc_in),
    .instr_in(instr_in[63:0]), .slot_valid_in(sv_in[1:0]), .flush(flush),
    .out_valid(vld0), .out_ready(out_ready), .pc_out(pc0), .instr_out(ins0),
    .slot_valid_out(sv0), .bubble_clr(bubble_clr), .bubble_cnt(bub0));

  pr_id_multi #(.ISSUE_W(1), .XLEN(32), .NOP_INSTR(32'h0000_0013), .CNT_W(16)) u_dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy1), .pc_in(pc_in),
    .instr_in(instr_in[31:0]), .slot_valid_in(sv_in[0:0]), .flush(flush),
    .out_valid(vld1), .out_ready(out_ready), .pc_out(pc1), .instr_out(ins1),
    .slot_valid_out(sv1), .bubble_clr(bubble_clr), .bubble_cnt(bub1));

  pr_id_multi #(.ISSUE_W(4), .XLEN(32), .NOP_INSTR(32'h0000_0013), .CNT_W(4)) u_dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy2), .pc_in(pc_in),
    .instr_in(instr_in), .slot_valid_in(sv_in), .flush(flush),
    .out_valid(vld2), .out_ready(out_ready), .pc_out(pc2), .instr_out(ins2),
    .slot_valid_out(sv2), .bubble_clr(bubble_clr), .bubble_cnt(bub2));

  logic         g_rdy [ND];
  logic         g_vld [ND];
  logic [31:0]  g_pc  [ND];
  logic [127:0] g_ins [ND];
  logic [3:0]   g_sv  [ND];
  logic [15:0]  g_bub [ND];

  always_comb begin
    g_rdy[0] = rdy0; g_rdy[1] = rdy1; g_rdy[2] = rdy2;
    g_vld[0] = vld0; g_vld[1] = vld1; g_vld[2] = vld2;
    g_pc[0]  = pc0;  g_pc[1]  = pc1;  g_pc[2]  = pc2;
    g_ins[0] = {64'd0, ins0}; g_ins[1] = {96'd0, ins1}; g_ins[2] = ins2;
    g_sv[0]  = {2'd0, sv0};   g_sv[1]  = {3'd0, sv1};   g_sv[2]  = sv2;
    g_bub[0] = bub0; g_bub[1] = bub1; g_bub[2] = {12'd0, bub2};
  end

  int unsigned dw   [ND] = '{2, 1, 4};
  int unsigned cmax [ND] = '{65535, 65535, 15};
  logic [31:0] nop  [ND] = '{32'h0000_0000, 32'h0000_0013, 32'h0000_0013};

  // Reference model: up to two queued bundles per configuration, oldest first
  logic [31:0]  m_pc  [ND][2];
  logic [127:0] m_ins [ND][2];
  logic [3:0]   m_sv  [ND][2];
  int           m_cnt [ND];
  int unsigned  m_bub [ND];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input int i, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d actual=%h expected=%h at %0t", nm, i, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < ND; i++) begin
      m_cnt[i] = 0;
      m_bub[i] = 0;
    end
  endtask

  task automatic model_step(input int i);
    logic [3:0]   svm;
    logic [127:0] im;
    bit           ofire, ifire;
    ofire = (m_cnt[i] > 0) && out_ready;
    ifire = in_valid && (m_cnt[i] < 2);
    if (bubble_clr) m_bub[i] = 0;
    else if (m_cnt[i] == 0 && m_bub[i] < cmax[i]) m_bub[i]++;
    if (flush) begin
      m_cnt[i] = 0;
    end else begin
      if (ofire) begin
        m_pc[i][0] = m_pc[i][1]; m_ins[i][0] = m_ins[i][1]; m_sv[i][0] = m_sv[i][1];
        m_cnt[i]--;
      end
      svm = sv_in & 4'((5'd1 << dw[i]) - 5'd1);
      if (ifire && svm != 4'd0) begin
        im = '0;
        for (int k = 0; k < int'(dw[i]); k++)
          im[k*32 +: 32] = svm[k] ? instr_in[k*32 +: 32] : nop[i];
        m_pc[i][m_cnt[i]] = pc_in; m_ins[i][m_cnt[i]] = im; m_sv[i][m_cnt[i]] = svm;
        m_cnt[i]++;
      end
    end
  endtask

  task automatic compare(input int i);
    chk("in_ready",   i, 128'(g_rdy[i]), 128'(m_cnt[i] < 2));
    chk("out_valid",  i, 128'(g_vld[i]), 128'(m_cnt[i] > 0));
    chk("bubble_cnt", i, 128'(g_bub[i]), 128'(m_bub[i]));
    if (m_cnt[i] > 0) begin
      chk("pc_out",         i, 128'(g_pc[i]), 128'(m_pc[i][0]));
      chk("instr_out",      i, g_ins[i],      m_ins[i][0]);
      chk("slot_valid_out", i, 128'(g_sv[i]), 128'(m_sv[i][0]));
    end
  endtask

  task automatic cycle();
    for (int i = 0; i < ND; i++) model_step(i);
    @(posedge clk);
    #1;
    for (int i = 0; i < ND; i++) compare(i);
  endtask

  task automatic chk_reset_vals();
    for (int i = 0; i < ND; i++) begin
      chk("rst_in_ready",  i, 128'(g_rdy[i]), 128'd1);
      chk("rst_out_valid", i, 128'(g_vld[i]), 128'd0);
      chk("rst_pc",        i, 128'(g_pc[i]),  128'd0);
      chk("rst_instr",     i, g_ins[i],       128'd0);
      chk("rst_sv",        i, 128'(g_sv[i]),  128'd0);
      chk("rst_bubble",    i, 128'(g_bub[i]), 128'd0);
    end
  endtask

  typedef struct {
    logic        iv, ordy, fl;
    logic [31:0] pc;
    logic [63:0] ins;
    logic [1:0]  sv;
    logic        e_vld, e_rdy, e_data;
    logic [31:0] e_pc;
    logic [63:0] e_ins;
    logic [1:0]  e_sv;
  } vec_t;

  function automatic vec_t mk(logic iv, logic ordy, logic fl, logic [31:0] pc, logic [63:0] ins,
                              logic [1:0] sv, logic ev, logic er, logic ed, logic [31:0] epc,
                              logic [63:0] eins, logic [1:0] esv);
    vec_t v;
    v.iv = iv; v.ordy = ordy; v.fl = fl; v.pc = pc; v.ins = ins; v.sv = sv;
    v.e_vld = ev; v.e_rdy = er; v.e_data = ed; v.e_pc = epc; v.e_ins = eins; v.e_sv = esv;
    return v;
  endfunction

  initial begin
    vec_t        tbl [17];
    logic [63:0] a, b, p, pe;
    a  = 64'h2222_2222_1111_1111;
    b  = 64'h4444_4444_3333_3333;
    p  = 64'hDEAD_BEEF_5555_5555;
    pe = 64'h0000_0000_5555_5555;
    //             iv ordy fl pc        ins sv     vld rdy data pc       ins sv
    tbl[0]  = mk(1, 1, 0, 32'h100, a, 2'b11, 1, 1, 1, 32'h100, a,  2'b11);
    tbl[1]  = mk(1, 0, 0, 32'h108, b, 2'b11, 1, 0, 1, 32'h100, a,  2'b11);
    tbl[2]  = mk(1, 0, 0, 32'h110, a, 2'b11, 1, 0, 1, 32'h100, a,  2'b11);
    tbl[3]  = mk(0, 1, 0, 32'h0,   a, 2'b11, 1, 1, 1, 32'h108, b,  2'b11);
    tbl[4]  = mk(0, 1, 0, 32'h0,   a, 2'b11, 0, 1, 0, 32'h0,   a,  2'b00);
    tbl[5]  = mk(1, 0, 0, 32'h200, p, 2'b01, 1, 1, 1, 32'h200, pe, 2'b01);
    tbl[6]  = mk(0, 1, 0, 32'h0,   a, 2'b11, 0, 1, 0, 32'h0,   a,  2'b00);
    tbl[7]  = mk(1, 1, 0, 32'h300, a, 2'b00, 0, 1, 0, 32'h0,   a,  2'b00);
    tbl[8]  = mk(0, 1, 0, 32'h0,   a, 2'b11, 0, 1, 0, 32'h0,   a,  2'b00);
    tbl[9]  = mk(1, 0, 0, 32'h400, a, 2'b11, 1, 1, 1, 32'h400, a,  2'b11);
    tbl[10] = mk(1, 0, 0, 32'h408, b, 2'b11, 1, 0, 1, 32'h400, a,  2'b11);
    tbl[11] = mk(1, 0, 1, 32'h410, a, 2'b11, 0, 1, 0, 32'h0,   a,  2'b00);
    tbl[12] = mk(0, 1, 0, 32'h0,   a, 2'b11, 0, 1, 0, 32'h0,   a,  2'b00);
    tbl[13] = mk(0, 1, 0, 32'h0,   a, 2'b11, 0, 1, 0, 32'h0,   a,  2'b00);
    tbl[14] = mk(1, 0, 0, 32'h500, b, 2'b11, 1, 1, 1, 32'h500, b,  2'b11);
    tbl[15] = mk(1, 1, 1, 32'h508, a, 2'b11, 0, 1, 0, 32'h0,   a,  2'b00);
    tbl[16] = mk(0, 1, 0, 32'h0,   a, 2'b11, 0, 1, 0, 32'h0,   a,  2'b00);

    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; bubble_clr = 1'b0;
    pc_in = '0; instr_in = '0; sv_in = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals();
    reset = 1'b0;

    // Idle bubble counting and saturation of the 4-bit counter
    repeat (10) cycle();
    chk("bub10_w16", 0, 128'(bub0), 128'd10);
    chk("bub10_w4",  2, 128'(bub2), 128'd10);
    repeat (10) cycle();
    chk("bub20_w16", 0, 128'(bub0), 128'd20);
    chk("bub20_sat", 2, 128'(bub2), 128'd15);
    bubble_clr = 1'b1;
    cycle();
    chk("bub_clr", 0, 128'(bub0), 128'd0);
    chk("bub_clr", 2, 128'(bub2), 128'd0);
    bubble_clr = 1'b0;

    // Directed handshake table on the 2-wide instance
    for (int r = 0; r < 17; r++) begin
      in_valid = tbl[r].iv; out_ready = tbl[r].ordy; flush = tbl[r].fl;
      pc_in = tbl[r].pc; instr_in = {64'd0, tbl[r].ins}; sv_in = {2'b00, tbl[r].sv};
      cycle();
      chk($sformatf("tbl%0d_out_valid", r), 0, 128'(vld0), 128'(tbl[r].e_vld));
      chk($sformatf("tbl%0d_in_ready", r),  0, 128'(rdy0), 128'(tbl[r].e_rdy));
      if (tbl[r].e_data) begin
        chk($sformatf("tbl%0d_pc", r),    0, 128'(pc0),  128'(tbl[r].e_pc));
        chk($sformatf("tbl%0d_instr", r), 0, 128'(ins0), 128'(tbl[r].e_ins));
        chk($sformatf("tbl%0d_sv", r),    0, 128'(sv0),  128'(tbl[r].e_sv));
      end
    end
    flush = 1'b0;

    // Async reset while holding a skid entry
    in_valid = 1'b1; out_ready = 1'b0; sv_in = 4'hF; instr_in = {a, b};
    pc_in = 32'h600; cycle();
    pc_in = 32'h608; cycle();
    chk("skid_in_ready", 0, 128'(rdy0), 128'd0);
    #2;
    reset = 1'b1;
    #1;
    chk_reset_vals();
    model_reset();
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    // Random traffic against the queue model
    for (int n = 0; n < 3000; n++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      out_ready  = (n < 1500) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 6) != 0);
      flush      = ($urandom_range(0, 15) == 0);
      bubble_clr = ($urandom_range(0, 31) == 0);
      pc_in      = $urandom;
      instr_in   = {$urandom, $urandom, $urandom, $urandom};
      sv_in      = 4'($urandom);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
